// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder stepping one 4-bit ripple slice per cycle; optional subtract via SUB_MODE_EN

// 4-bit ripple-carry slice reused once per nibble by the serial adder
module rca_4 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       cout_o
);
   logic [4:0] c;

   // Four chained full adders
   always_comb begin
      c     = '0;
      sum_o = '0;
      c[0]  = cin_i;
      for (int i = 0; i < 4; i++) begin
         sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
         c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
      end
      cout_o = c[4];
   end
endmodule

module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SUB_MODE_EN
   input  logic             sub,
   output logic             ovf,
`endif
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int N     = WIDTH / 4;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q;
   logic [WIDTH-1:0] opa_q, opb_q;
   logic             carry_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic [3:0]       s_sum;
   logic             s_cout;
   logic             sub_w;
   logic             last_step;

`ifdef SUB_MODE_EN
   assign sub_w = sub;
`else
   assign sub_w = 1'b0;
`endif

   // Low nibbles of the shifting operands always feed the single slice
   rca_4 u_rca (
      .a_i    (opa_q[3:0]),
      .b_i    (opb_q[3:0]),
      .cin_i  (carry_q),
      .sum_o  (s_sum),
      .cout_o (s_cout)
   );

   assign last_step = (idx_q == IDX_W'(N - 1));

   // Next-state logic for the IDLE -> RUN -> DONE sequence
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)  state_d = RUN;
         RUN:     if (last_step) state_d = DONE;
         DONE:    if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand capture, per-nibble accumulation and carry chaining between cycles
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  opa_q   <= a;
                  opb_q   <= sub_w ? ~b : b;
                  carry_q <= sub_w ? 1'b1 : cin;
                  idx_q   <= '0;
               end
            end
            RUN: begin
               sum_q[4*idx_q +: 4] <= s_sum;
               carry_q             <= s_cout;
               opa_q               <= opa_q >> 4;
               opb_q               <= opb_q >> 4;
               idx_q               <= idx_q + IDX_W'(1);
               if (last_step) cout_q <= s_cout;
            end
            default: ;
         endcase
      end
   end

`ifdef SUB_MODE_EN
   logic ovf_q;

   // Signed overflow from the MSB nibble: operand signs agree but the sum sign differs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (state_q == RUN && last_step) begin
         ovf_q <= (opa_q[3] == opb_q[3]) && (s_sum[3] != opa_q[3]);
      end
   end

   assign ovf = ovf_q;
`endif

   assign in_ready  = (state_q == IDLE) && rst_n;
   assign res_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - randomized bench with behavioural model for nibble_serial_adder
module tb_nibble_serial_adder;
   localparam int W = 16;
   localparam int N = W / 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0, in_ready, cin = 1'b0, res_valid, res_ready = 1'b0, cout;
   logic [W-1:0] a = '0, b = '0, sum;
   logic sub_i = 1'b0;
`ifdef SUB_MODE_EN
   logic ovf;
`endif

   logic in_valid4 = 1'b0, in_ready4, cin4 = 1'b0, res_valid4, res_ready4 = 1'b0, cout4;
   logic [3:0] a4 = '0, b4 = '0, sum4;
`ifdef SUB_MODE_EN
   logic ovf4;
`endif

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   nibble_serial_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin),
`ifdef SUB_MODE_EN
      .sub(sub_i), .ovf(ovf),
`endif
      .res_valid(res_valid), .res_ready(res_ready), .sum(sum), .cout(cout)
   );

   nibble_serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .cin(cin4),
`ifdef SUB_MODE_EN
      .sub(1'b0), .ovf(ovf4),
`endif
      .res_valid(res_valid4), .res_ready(res_ready4), .sum(sum4), .cout(cout4)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: result = (a + b' + c) mod 2^W, visible N edges after acceptance
   bit           m_idle = 1'b1, m_valid = 1'b0, m_clean = 1'b1;
   int           m_pend = 0;
   logic [W-1:0] m_sum = '0, p_sum;
   logic         m_cout = 1'b0, p_cout, m_ovf = 1'b0, p_ovf;

   always @(posedge clk) begin
      logic [W:0]   full;
      logic [W-1:0] eb;
      logic         c0;
      if (!rst_n) begin
         m_idle = 1'b1; m_valid = 1'b0; m_pend = 0; m_clean = 1'b1;
         m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
      end else if (m_valid) begin
         if (res_ready) begin m_valid = 1'b0; m_idle = 1'b1; end
      end else if (m_pend > 0) begin
         m_pend--;
         if (m_pend == 0) begin
            m_valid = 1'b1; m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
         end
      end else if (m_idle && in_valid) begin
`ifdef SUB_MODE_EN
         eb = sub_i ? ~b : b;
         c0 = sub_i ? 1'b1 : cin;
`else
         eb = b;
         c0 = cin;
`endif
         full   = {1'b0, a} + {1'b0, eb} + (W+1)'(c0);
         p_sum  = full[W-1:0];
         p_cout = full[W];
         p_ovf  = (a[W-1] == eb[W-1]) && (p_sum[W-1] != a[W-1]);
         m_idle = 1'b0; m_pend = N; m_clean = 1'b0;
      end
   end

   // Compare DUT against model every cycle, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", 64'(in_ready), 64'(m_idle && rst_n));
         chk("res_valid", 64'(res_valid), 64'(m_valid));
         if (m_valid || m_clean) begin
            chk("sum", 64'(sum), 64'(m_sum));
            chk("cout", 64'(cout), 64'(m_cout));
`ifdef SUB_MODE_EN
            chk("ovf", 64'(ovf), 64'(m_ovf));
`endif
         end
      end
   end

   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         input logic sv, input int hold,
                         output logic [W-1:0] s_o, output logic co_o, output logic ov_o,
                         output int lat);
      int t = 0;
      while (!in_ready && t < 50) begin @(posedge clk); #2; t++; end
      if (t >= 50) chk("in_ready_timeout", 64'(in_ready), 64'd1);
      a = av; b = bv; cin = cv; sub_i = sv; in_valid = 1'b1;
      @(posedge clk); #2;
      in_valid = 1'b0; a = $urandom; b = $urandom;
      lat = 0;
      while (!res_valid && lat < 50) begin @(posedge clk); #2; lat++; end
      s_o = sum; co_o = cout;
`ifdef SUB_MODE_EN
      ov_o = ovf;
`else
      ov_o = 1'b0;
`endif
      for (int i = 0; i < hold; i++) begin
         in_valid = (i == 2);
         @(posedge clk); #2;
         chk("hold_sum", 64'(sum), 64'(s_o));
      end
      in_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk); #2;
      res_ready = 1'b0;
      chk("released", 64'(res_valid), 64'd0);
   endtask

   initial begin
      logic [W-1:0] s;
      logic co, ov;
      int lat;
      repeat (3) @(posedge clk);
      #2;
      chk_en = 1'b1;
      chk("reset_sum", 64'(sum), 64'd0);
      chk("reset_valid", 64'(res_valid), 64'd0);
      rst_n = 1'b1;

      run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, s, co, ov, lat);
      chk("lit_5555", 64'(s), 64'h5555);
      chk("lit_5555_cout", 64'(co), 64'd0);
      chk("latency", 64'(lat), 64'd4);
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, s, co, ov, lat);
      chk("lit_chain", 64'(s), 64'h0000);
      chk("lit_chain_cout", 64'(co), 64'd1);
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0, s, co, ov, lat);
      chk("lit_ffff", 64'(s), 64'hFFFF);
      chk("lit_ffff_cout", 64'(co), 64'd1);
      run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 10, s, co, ov, lat);
      chk("lit_bp", 64'(s), 64'h5555);
`ifdef SUB_MODE_EN
      run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, s, co, ov, lat);
      chk("sub_fffe", 64'(s), 64'hFFFE);
      chk("sub_fffe_cout", 64'(co), 64'd0);
      chk("sub_fffe_ovf", 64'(ov), 64'd0);
      run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, s, co, ov, lat);
      chk("sub_7fff", 64'(s), 64'h7FFF);
      chk("sub_7fff_cout", 64'(co), 64'd1);
      chk("sub_7fff_ovf", 64'(ov), 64'd1);
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, s, co, ov, lat);
      chk("add_ovf_sum", 64'(s), 64'h8000);
      chk("add_ovf", 64'(ov), 64'd1);
`endif

      // Reset after two RUN edges aborts the operation
      a = 16'h1234; b = 16'h4321; in_valid = 1'b1;
      @(posedge clk); #2;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      @(posedge clk); #2;
      chk("abort_valid", 64'(res_valid), 64'd0);
      chk("abort_sum", 64'(sum), 64'd0);
      chk("abort_cout", 64'(cout), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("abort_ready", 64'(in_ready), 64'd1);
      run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, s, co, ov, lat);
      chk("after_abort", 64'(s), 64'h0002);

      for (int k = 0; k < 40; k++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3),
                s, co, ov, lat);
      end

      // WIDTH=4 instance: single step
      a4 = 4'h9; b4 = 4'h8; cin4 = 1'b1; in_valid4 = 1'b1;
      @(posedge clk); #2;
      in_valid4 = 1'b0;
      lat = 0;
      while (!res_valid4 && lat < 20) begin @(posedge clk); #2; lat++; end
      chk("w4_latency", 64'(lat), 64'd1);
      chk("w4_sum", 64'(sum4), 64'h2);
      chk("w4_cout", 64'(cout4), 64'd1);
      res_ready4 = 1'b1;
      @(posedge clk); #2;
      res_ready4 = 1'b0;
      chk("w4_released", 64'(res_valid4), 64'd0);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
